// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory read channel between the fetch unit (master) and the
// instruction memory (slave).
//   imem_req   : read request, master -> slave
//   imem_addr  : 32-bit word address (the current PC), master -> slave
//   imem_rdata : 32-bit instruction word, slave -> master, valid with ack
//   imem_ack   : single-cycle read completion strobe, slave -> master
// ---------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: holds the PC, requests one instruction word at a
// time from instruction memory, presents it to the decoder until the
// execute stage retires it, then selects the next PC.
//
// Ports
//   clk        : single clock, rising edge
//   reset_n    : synchronous active-low reset
//   imem       : instruction-memory channel (master side)
//   PCSrc      : next-PC select 00 PC+4, 01 PC+ImmExt, 10 ALUResult, 11 PC
//   ImmExt     : sign-extended branch/jal offset
//   ALUResult  : jalr target (bit 0 is forced to 0)
//   ExecDone   : current instruction retired, advance the PC
//   Instr      : held instruction, all-zero whenever InstrValid=0
//   InstrValid : Instr is valid for execution
//   PC/PCPlus4 : current PC and PC+4
//   Misaligned : sticky next-PC alignment fault (FSM halts)
//   FetchErr   : sticky fetch timeout (FSM halts)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [7:0]  MAX_WAIT = 8'd255
) (
    input  logic         clk,
    input  logic         reset_n,
    fetch_unit_if.master imem,
    input  logic [1:0]   PCSrc,
    input  logic [31:0]  ImmExt,
    input  logic [31:0]  ALUResult,
    input  logic         ExecDone,
    output logic [31:0]  Instr,
    output logic         InstrValid,
    output logic [31:0]  PC,
    output logic [31:0]  PCPlus4,
    output logic         Misaligned,
    output logic         FetchErr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_VALID = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] instr_q, instr_d;
    logic        misaligned_q, misaligned_d;
    logic        fetch_err_q, fetch_err_d;

    logic [31:0] next_pc;
    logic [31:0] jalr_target;
    logic [7:0]  wait_inc;

    // jalr clears bit 0 of the target; bit 1 still reaches the alignment check
    assign jalr_target = ALUResult & 32'hFFFF_FFFE;
    assign wait_inc    = wait_cnt_q + 8'd1;

    always_comb begin
        next_pc = pc_q;
        case (PCSrc)
            2'b00:   next_pc = pc_q + 32'd4;
            2'b01:   next_pc = pc_q + ImmExt;
            2'b10:   next_pc = jalr_target;
            default: next_pc = pc_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        wait_cnt_d   = wait_cnt_q;
        instr_d      = instr_q;
        misaligned_d = misaligned_q;
        fetch_err_d  = fetch_err_q;

        case (state_q)
            S_IDLE: begin
                state_d    = S_FETCH;
                wait_cnt_d = 8'd0;
            end
            S_FETCH: begin
                // ack is checked first so it wins over a coinciding timeout
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = S_VALID;
                end else if (wait_inc == MAX_WAIT) begin
                    wait_cnt_d  = wait_inc;
                    fetch_err_d = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            S_VALID: begin
                if (ExecDone) begin
                    if (next_pc[1:0] != 2'b00) begin
                        // PC keeps the address of the faulting instruction
                        misaligned_d = 1'b1;
                        state_d      = S_HALT;
                    end else begin
                        pc_d       = next_pc;
                        wait_cnt_d = 8'd0;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            wait_cnt_q   <= 8'd0;
            instr_q      <= 32'h0000_0000;
            misaligned_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            wait_cnt_q   <= wait_cnt_d;
            instr_q      <= instr_d;
            misaligned_q <= misaligned_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    // Gating with reset_n keeps the request low for the whole reset window,
    // even when reset is asserted in the middle of a FETCH cycle.
    assign imem.imem_req  = (state_q == S_FETCH) && reset_n;
    assign imem.imem_addr = pc_q;

    assign InstrValid = (state_q == S_VALID);
    assign Instr      = InstrValid ? instr_q : 32'h0000_0000;
    assign PC         = pc_q;
    assign PCPlus4    = pc_q + 32'd4;
    assign Misaligned = misaligned_q;
    assign FetchErr   = fetch_err_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter MAX_WAIT, default 8'd255: maximum cycles spent in FETCH without imem_ack before a fetch error.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 PCSrc  input  2  next-PC select from the main decoder: 00 PC+4, 01 PC+ImmExt, 10 ALUResult, 11 reserved.
REQ-006 ImmExt  input  32  sign-extended branch/jal offset.
REQ-007 ALUResult  input  32  jalr target.
REQ-008 ExecDone  input  1  current instruction retired; advance the PC.
REQ-009 imem_req  output  1  instruction-memory read request.
REQ-010 imem_addr  output  32  instruction-memory word address, equal to PC.
REQ-011 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-012 imem_ack  input  1  read completion strobe.
REQ-013 Instr  output  32  held instruction; op = Instr[6:0] drives the decoder.
REQ-014 InstrValid  output  1  Instr is valid for execution.
REQ-015 PC / PCPlus4  output  32 each  current PC and PC+4.
REQ-016 Misaligned  output  1  sticky: next-PC alignment fault.
REQ-017 FetchErr  output  1  sticky: fetch timeout.

Function
REQ-018 The FSM SHALL have the states IDLE, FETCH, VALID and HALT, encoded in 2 bits.
REQ-019 IDLE: outputs are quiescent; the FSM SHALL go to FETCH on the next cycle.
REQ-020 FETCH: imem_req SHALL be 1 and imem_addr SHALL be PC.
- On imem_ack=1: capture imem_rdata into Instr and go to VALID.
REQ-021 FETCH wait counter: 8 bits, incremented each FETCH cycle without an ack.
- When the counter equals MAX_WAIT without an ack: go to HALT and set FetchErr.
- If imem_ack and the counter limit coincide, imem_ack SHALL win.
REQ-022 The wait counter SHALL clear on every entry to FETCH.
REQ-023 VALID: InstrValid SHALL be 1 and imem_req SHALL be 0.
- While ExecDone=0, the FSM SHALL stay in VALID with Instr and PC stable.
REQ-024 VALID with ExecDone=1: the PC SHALL load the next PC and the FSM SHALL go to FETCH.
- 00: PC+4.
- 01: PC+ImmExt.
- 10: {ALUResult[31:1],1'b0}.
- 11: PC unchanged (refetch).
- All sums are modulo 2^32; wrap-around is silent.
REQ-025 If the computed next PC has bits [1:0] != 2'b00, the PC SHALL NOT update, the FSM SHALL go to HALT, and Misaligned SHALL be set.
REQ-026 PCSrc, ImmExt and ALUResult SHALL be sampled only in VALID with ExecDone=1; they are ignored in every other state.
REQ-027 Instr SHALL read 32'h0000_0000 whenever InstrValid=0, so the decoder sees the all-zero op.
REQ-028 HALT: imem_req=0 and InstrValid=0; the FSM SHALL leave HALT only through reset.
REQ-029 PCPlus4 SHALL be combinational PC+4 in all states.
REQ-030 Fetch latency: the first InstrValid SHALL assert 2 cycles after reset release plus the imem_ack wait cycles.
- With zero wait states, throughput SHALL be one instruction per 2 cycles.
REQ-031 An imem_ack outside FETCH SHALL be ignored.

Reset
REQ-032 On reset_n=0 at a clock edge, the block SHALL reset as follows, overriding any state including mid-FETCH and HALT:
- FSM to IDLE; PC to RESET_PC; counter to 0.
- Instr, InstrValid, imem_req, Misaligned and FetchErr to 0.
REQ-033 While reset_n=0, imem_req SHALL remain 0.

Verification
REQ-034 Release reset, ack in the first FETCH cycle with rdata 32'h00500093 -> imem_addr=0; InstrValid=1 and Instr=32'h00500093 two cycles after release.
REQ-035 PC=0x10, PCSrc=01, ImmExt=32'hFFFF_FFF8, ExecDone=1 -> PC=0x08 and the next FETCH addresses 0x08.
REQ-036 PCSrc=10, ALUResult=32'h0000_0103 -> bit0 cleared gives 0x102, which is misaligned -> HALT, Misaligned=1, PC unchanged, imem_req stays 0.
REQ-037 MAX_WAIT=4, no ack -> FetchErr=1 and HALT after 4 FETCH cycles; a separate case with ack on cycle 4 -> VALID with FetchErr=0.
REQ-038 reset_n=0 during FETCH wait -> next edge: imem_req=0, PC=RESET_PC, IDLE; refetch from RESET_PC after release.
REQ-039 PC=32'hFFFF_FFFC, PCSrc=00 -> PC wraps to 0x0 with no flag set.
